// File: rtl/uart_tx_seq_if.sv
// uart_tx_seq_if: start/abort control, RAM read port and transmitter handshake for uart_tx_seq
interface uart_tx_seq_if #(parameter int ADDR_W = 8, parameter int LEN_W = 9);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  length;
  logic              abort;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rd_data;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              tx_bits_ok;
  logic              busy;
  logic              done;
  logic              aborted;
  modport master (
    output start, start_addr, length, abort, ram_rd_data, tx_bits_ok,
    input  ram_rd_en, ram_addr, tx_ready, tx_data, busy, done, aborted
  );
  modport slave (
    input  start, start_addr, length, abort, ram_rd_data, tx_bits_ok,
    output ram_rd_en, ram_addr, tx_ready, tx_data, busy, done, aborted
  );
endinterface

// File: rtl/uart_tx_seq.sv
// uart_tx_seq: streams a RAM block byte by byte into a UART transmitter, prefetching the next byte during transmission
module uart_tx_seq #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) (
  input logic         sys_clk,
  input logic         rst_n,
  uart_tx_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, LATCH, WAIT_RDY, REQ, GAP, FIN} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        data_q, data_d;
  logic              gap_q, gap_d, done_q, done_d, abt_q, abt_d;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      gap_q   <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
    end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    gap_d   = 1'b0;
    done_d  = 1'b0;
    abt_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        addr_d  = bus.start_addr;
        cnt_d   = bus.length;
        state_d = bus.length == '0 ? FIN : RD;
      end
      RD:       state_d = LATCH;
      LATCH: begin
        data_d  = bus.ram_rd_data;
        state_d = WAIT_RDY;
      end
      WAIT_RDY: state_d = bus.tx_bits_ok ? REQ : WAIT_RDY;
      // tx_bits_ok falling means the transmitter has captured tx_data
      REQ: if (!bus.tx_bits_ok) begin
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = GAP;
      end
      GAP: begin
        gap_d   = !gap_q;
        state_d = !gap_q ? GAP : cnt_q == '0 ? FIN : RD;
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
      abt_d   = 1'b1;
    end
  end
  assign bus.ram_rd_en = state_q == RD;
  assign bus.ram_addr  = addr_q;
  assign bus.tx_ready  = state_q == REQ;
  assign bus.tx_data   = data_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = done_q;
  assign bus.aborted   = abt_q;
endmodule

// File: tb/tb_uart_tx_seq.sv
// tb_uart_tx_seq: directed bench with a RAM, a UART transmitter/receiver model and a block-level expectation model
module tb_uart_tx_seq;
  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  uart_tx_seq_if #(.ADDR_W(8), .LEN_W(9)) bus ();
  uart_tx_seq #(.ADDR_W(8), .LEN_W(9)) dut (.sys_clk(sys_clk), .rst_n(rst_n), .bus(bus));

  int vecs = 0, errs = 0, cyc = 0;
  logic [7:0] ram [256];
  logic [7:0] exp_addr[$], exp_byte[$], exp_line[$], rd_log[$], rx_log[$];
  int st_t[$];
  int exp_done = 0, exp_abt = 0, acc_n = 0, acc_t = 0, done_t = 0;
  logic use_tx = 1'b1, ok_force = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    vecs++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  always @(posedge sys_clk)
    if (bus.ram_rd_en) bus.ram_rd_data <= ram[bus.ram_addr];

  // transmitter: 8 clocks per bit; ready in IDLE/STOP once the first baud tick after reset has passed
  logic [3:0] ph;
  logic [2:0] bc;
  logic armed, acc, tx_ok_m, line;
  logic [7:0] sh;
  always @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      ph <= 4'd0; bc <= 3'd0; armed <= 1'b0; acc <= 1'b0; sh <= 8'h00;
    end else begin
      bc  <= bc + 3'd1;
      acc <= 1'b0;
      if (bc == 3'd7) begin
        armed <= 1'b1;
        if (use_tx && tx_ok_m && bus.tx_ready) begin
          ph <= 4'd1; sh <= bus.tx_data; acc <= 1'b1;
        end else if (ph == 4'd10) ph <= 4'd0;
        else if (ph != 4'd0) ph <= ph + 4'd1;
      end
    end
  assign tx_ok_m = armed && (ph == 4'd0 || ph == 4'd10);
  assign line = ph == 4'd1 ? 1'b0 : (ph >= 4'd2 && ph <= 4'd9) ? sh[3'(ph - 4'd2)] : 1'b1;
  assign bus.tx_bits_ok = use_tx ? tx_ok_m : ok_force;

  // receiver and per-cycle comparison against the expectation model
  initial begin
    int rc;
    bit rx_on;
    logic [7:0] rb;
    rc = 0; rx_on = 0; rb = 8'h00;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (!rst_n) rx_on = 0;
      else begin
        if (!rx_on) begin
          if (!line) begin rx_on = 1; rc = 1; st_t.push_back(cyc); end
        end else begin
          if (rc >= 12 && rc <= 68 && rc % 8 == 4) rb = {line, rb[7:1]};
          if (rc == 76) begin
            rx_on = 0;
            rx_log.push_back(rb);
            chk("stop_bit", int'(line), 1);
            chk("line_pending", int'(exp_line.size() > 0), 1);
            if (exp_line.size() > 0) chk("line_byte", rb, exp_line.pop_front());
          end
          rc++;
        end
        if (bus.ram_rd_en) begin
          rd_log.push_back(bus.ram_addr);
          chk("read_pending", int'(exp_addr.size() > 0), 1);
          if (exp_addr.size() > 0) chk("read_addr", bus.ram_addr, exp_addr.pop_front());
        end
        if (bus.tx_ready) begin
          chk("tx_pending", int'(exp_byte.size() > 0), 1);
          if (exp_byte.size() > 0) chk("tx_data", bus.tx_data, exp_byte[0]);
        end
        if (acc) begin
          acc_n++; acc_t = cyc;
          chk("accept_pending", int'(exp_byte.size() > 0), 1);
          if (exp_byte.size() > 0) exp_line.push_back(exp_byte.pop_front());
        end
        if (bus.done) begin
          done_t = cyc;
          chk("done_expected", int'(exp_done > 0), 1);
          if (exp_done > 0) exp_done--;
          chk("done_not_busy", int'(bus.busy), 0);
        end
        if (bus.aborted) begin
          chk("aborted_expected", int'(exp_abt > 0), 1);
          if (exp_abt > 0) exp_abt--;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic do_start(input logic [7:0] a, input int n, input bit taken);
    logic [7:0] ad;
    if (taken) begin
      for (int k = 0; k < n; k++) begin
        ad = a + 8'(k);
        exp_addr.push_back(ad);
        exp_byte.push_back(ram[ad]);
      end
      exp_done++;
    end
    bus.start = 1'b1; bus.start_addr = a; bus.length = 9'(n);
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n;
    n = 0;
    while (bus.busy && n < lim) begin step(1); n++; end
    chk({name, "_idle"}, int'(bus.busy), 0);
  endtask

  task automatic end_checks(input string name);
    chk({name, "_reads_left"}, exp_addr.size(), 0);
    chk({name, "_bytes_left"}, exp_byte.size(), 0);
    chk({name, "_line_left"}, exp_line.size(), 0);
    chk({name, "_done_left"}, exp_done, 0);
    chk({name, "_abort_left"}, exp_abt, 0);
  endtask

  task automatic flush();
    exp_addr.delete(); exp_byte.delete(); exp_line.delete();
    exp_done = 0; exp_abt = 0;
  endtask

  initial begin
    int n;
    bus.start = 1'b0; bus.start_addr = 8'h00; bus.length = 9'd0; bus.abort = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 37 + 11);
    ram[8'h10] = 8'h55; ram[8'h11] = 8'hA3; ram[8'h12] = 8'h0F;
    ram[8'hFE] = 8'h81; ram[8'hFF] = 8'h7E; ram[8'h00] = 8'h3C; ram[8'h01] = 8'hC5;
    ram[8'h60] = 8'hC3;
    step(2);
    chk("rst_tx_ready", int'(bus.tx_ready), 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_rd_en", int'(bus.ram_rd_en), 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_aborted", int'(bus.aborted), 0);
    rst_n = 1'b1;
    step(2);

    // three bytes back to back on the line
    rx_log.delete(); st_t.delete();
    do_start(8'h10, 3, 1);
    wait_idle("t1", 1000);
    step(100);
    end_checks("t1");
    chk("t1_rx_count", rx_log.size(), 3);
    if (rx_log.size() == 3) begin
      chk("t1_rx0", rx_log[0], 8'h55);
      chk("t1_rx1", rx_log[1], 8'hA3);
      chk("t1_rx2", rx_log[2], 8'h0F);
    end
    chk("t1_frames", st_t.size(), 3);
    if (st_t.size() == 3) begin
      chk("t1_spacing01", st_t[1] - st_t[0], 80);
      chk("t1_spacing12", st_t[2] - st_t[1], 80);
    end
    chk("t1_done_latency", done_t - acc_t, 4);

    // address wraps past 0xFF
    rd_log.delete();
    do_start(8'hFE, 4, 1);
    wait_idle("t2", 1000);
    step(100);
    end_checks("t2");
    chk("t2_reads", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      chk("t2_rd0", rd_log[0], 8'hFE);
      chk("t2_rd1", rd_log[1], 8'hFF);
      chk("t2_rd2", rd_log[2], 8'h00);
      chk("t2_rd3", rd_log[3], 8'h01);
    end

    // zero length: done two cycles after start, nothing read or sent
    do_start(8'h44, 0, 1);
    chk("t3_busy", int'(bus.busy), 1);
    chk("t3_done_early", int'(bus.done), 0);
    step(1);
    chk("t3_done", int'(bus.done), 1);
    step(1);
    chk("t3_done_once", int'(bus.done), 0);
    step(2);
    end_checks("t3");

    // second start while busy is ignored
    rd_log.delete();
    do_start(8'h20, 2, 1);
    step(5);
    do_start(8'h40, 3, 0);
    wait_idle("t4", 1000);
    step(100);
    end_checks("t4");
    chk("t4_reads", rd_log.size(), 2);
    if (rd_log.size() == 2) chk("t4_rd1", rd_log[1], 8'h21);

    // abort while requesting, before the transmitter accepts
    use_tx = 1'b0; ok_force = 1'b0;
    do_start(8'h30, 2, 1);
    step(4);
    chk("t5_wait_ready", int'(bus.tx_ready), 0);
    ok_force = 1'b1;
    n = 0;
    while (!bus.tx_ready && n < 10) begin step(1); n++; end
    chk("t5_req", int'(bus.tx_ready), 1);
    bus.abort = 1'b1; exp_abt = 1; exp_done = 0;
    step(1);
    bus.abort = 1'b0;
    exp_addr.delete(); exp_byte.delete();
    chk("t5_ready_fall", int'(bus.tx_ready), 0);
    chk("t5_aborted", int'(bus.aborted), 1);
    chk("t5_busy", int'(bus.busy), 0);
    chk("t5_no_done", int'(bus.done), 0);
    step(1);
    chk("t5_aborted_pulse", int'(bus.aborted), 0);
    step(2);
    end_checks("t5");
    use_tx = 1'b1; ok_force = 1'b0;

    // abort in IDLE does nothing; abort together with start lets start win
    bus.abort = 1'b1;
    step(2);
    chk("t6_idle_abort", int'(bus.busy), 0);
    do_start(8'h12, 1, 1);
    bus.abort = 1'b0;
    chk("t6_start_wins", int'(bus.busy), 1);
    wait_idle("t6", 1000);
    step(100);
    end_checks("t6");

    // reset during byte 2 of 5, then a clean single-byte block
    n = acc_n;
    do_start(8'h50, 5, 1);
    while (acc_n < n + 2 && acc_n < n + 100 && cyc < 90000) step(1);
    step(20);
    rst_n = 1'b0;
    flush();
    step(2);
    chk("t7_rst_busy", int'(bus.busy), 0);
    chk("t7_rst_ready", int'(bus.tx_ready), 0);
    rst_n = 1'b1;
    rx_log.delete();
    step(1);
    do_start(8'h60, 1, 1);
    step(2);
    chk("t7_waits_tx", int'(bus.tx_ready), 0);
    chk("t7_busy", int'(bus.busy), 1);
    wait_idle("t7", 1000);
    step(100);
    end_checks("t7");
    chk("t7_rx_count", rx_log.size(), 1);
    if (rx_log.size() == 1) chk("t7_rx0", rx_log[0], 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_seq.md
UART_TX_SEQ -- requirements
Module: uart_tx_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, RAM address width.
REQ-002 The block SHALL have parameter LEN_W, default 9, length width, so lengths 0..256 are legal at ADDR_W=8.
REQ-003 The block SHALL have port sys_clk, input, 1, system clock (100 MHz); one clock; every flop SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1, single-cycle request to transmit a RAM block.
REQ-006 The block SHALL have port start_addr, input, ADDR_W, first RAM address of the block, sampled with start.
REQ-007 The block SHALL have port length, input, LEN_W, byte count, sampled with start.
REQ-008 The block SHALL have port abort, input, 1, cancels the current block.
REQ-009 The block SHALL have port ram_rd_en, output, 1, RAM read strobe.
REQ-010 The block SHALL have port ram_addr, output, ADDR_W, RAM read address.
REQ-011 The block SHALL have port ram_rd_data, input, 8, RAM read data, valid exactly 1 cycle after ram_rd_en.
REQ-012 The block SHALL have port tx_ready, output, 1, request to the UART transmitter.
REQ-013 The block SHALL have port tx_data, output, 8, byte presented to the transmitter.
REQ-014 The block SHALL have port tx_bits_ok, input, 1, transmitter is in STOP or IDLE (can accept a byte).
REQ-015 The block SHALL have port busy, output, 1, a block is in progress.
REQ-016 The block SHALL have port done, output, 1, one-cycle pulse when the last byte has been accepted by the transmitter.
REQ-017 The block SHALL have port aborted, output, 1, one-cycle pulse on abort completion.

Function
REQ-018 The state machine SHALL have states IDLE, RD, LATCH, WAIT_RDY, REQ, GAP and FIN.
REQ-019 IDLE: on start=1, the block SHALL load addr=start_addr and cnt=length, then go to FIN if length==0 (no RAM read, no tx_ready), else to RD.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 RD: the block SHALL drive ram_rd_en=1 for 1 cycle with ram_addr=addr, then go to LATCH.
REQ-022 LATCH: the block SHALL register tx_data<=ram_rd_data, then go to WAIT_RDY.
REQ-023 WAIT_RDY: the block SHALL hold tx_ready=0 until tx_bits_ok=1, then go to REQ.
REQ-024 REQ: the block SHALL drive tx_ready=1 with tx_data stable, and stay until tx_bits_ok=0, meaning the transmitter has entered START and captured the data.
REQ-025 On leaving REQ the block SHALL set addr<=addr+1 (mod 2^ADDR_W, 0xFF wraps to 0x00) and cnt<=cnt-1, then go to GAP.
REQ-026 GAP: the block SHALL hold tx_ready=0 for exactly 2 cycles (the transmitter's edge-detect minimum), then go to FIN if cnt==0, else to RD.
REQ-027 The prefetch read in RD/LATCH of byte N+1 SHALL overlap transmission of byte N; tx_data SHALL change only in LATCH, never while in REQ.
REQ-028 FIN: the block SHALL pulse done=1 for 1 cycle, then go to IDLE.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 Back-to-back bytes SHALL start at the transmitter's STOP bit with no extra idle bit, since tx_ready is raised while STOP has tx_bits_ok=1.
REQ-031 abort=1 in any non-IDLE state SHALL force tx_ready=0 and ram_rd_en=0 next cycle, pulse aborted for 1 cycle, go to IDLE, and not pulse done.
REQ-032 A byte already accepted by the transmitter when abort occurs SHALL finish on the line; this is not an error.
REQ-033 abort in IDLE SHALL have no effect.
REQ-034 If abort and start are both 1 in IDLE, start SHALL win.
REQ-035 If abort occurs in FIN, abort SHALL win: done=0 and aborted=1.
REQ-036 The block SHALL have no timeout; if tx_bits_ok never changes, the block SHALL wait indefinitely, and abort is the only escape.

Reset
REQ-037 rst_n=0 SHALL asynchronously force state=IDLE, tx_ready=0, tx_data=0x00, ram_rd_en=0, ram_addr=0, cnt=0, busy=0, done=0, aborted=0.
REQ-038 Reset mid-block SHALL discard all progress; the first start after reset SHALL begin cleanly.
REQ-039 Because tx_bits_ok is 0 until the transmitter's first baud tick after reset, the first byte SHALL wait in WAIT_RDY.

Verification
REQ-040 The bench SHALL cover: RAM[0x10..0x12]=0x55,0xA3,0x0F; start, start_addr=0x10, length=3 with the real transmitter -> the line carries 0x55,0xA3,0x0F LSB-first with no gap between stop and start bits, and done pulses once after the third acceptance.
REQ-041 The bench SHALL cover: start_addr=0xFE, length=4 -> reads at 0xFE,0xFF,0x00,0x01 in order.
REQ-042 The bench SHALL cover: length=0 -> done 2 cycles after start, with ram_rd_en and tx_ready never asserted.
REQ-043 The bench SHALL cover: a second start during busy -> ignored; byte count and addresses unchanged.
REQ-044 The bench SHALL cover: abort while in REQ before acceptance -> tx_ready falls next cycle, aborted=1 for 1 cycle, done never asserted, busy=0.
REQ-045 The bench SHALL cover: rst_n low during byte 2 of 5, then a new start of length=1 -> exactly 1 byte sent, and done pulses.
